// File: rtl/l2_request_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : l2_request_scheduler
// Description : Shares one L2 port between the L1 icache and dcache. The
//               dcache is preferred, and a starvation counter bounds the
//               icache wait. Optional performance counters are built when
//               ARB_PERF_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module l2_request_scheduler #(
    parameter int ADDR_W     = 16,
    parameter int LINE_W     = 128,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              icache_read,
    input  logic [ADDR_W-1:0] icache_address,
    output logic [LINE_W-1:0] icache_rdata,
    output logic              icache_resp,
    input  logic              dcache_read,
    input  logic              dcache_write,
    input  logic [ADDR_W-1:0] dcache_address,
    input  logic [LINE_W-1:0] dcache_wdata,
    output logic [LINE_W-1:0] dcache_rdata,
    output logic              dcache_resp,
    output logic [ADDR_W-1:0] l2cache_address,
    output logic [LINE_W-1:0] l2cache_wdata,
    output logic              l2_read,
    output logic              l2_write,
    input  logic [LINE_W-1:0] l2cache_rdata,
    input  logic              l2_resp,
    output logic [31:0]       perf_igrant,
    output logic [31:0]       perf_dgrant,
    output logic [31:0]       perf_wait
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] c_STARVE_MAX = 4'(STARVE_MAX);
    localparam logic [3:0] c_STARVE_SAT = 4'hF;

    state_t            state_q;
    logic              owner_dc_q;
    logic [3:0]        starve_q;
    logic [3:0]        starve_d;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic [LINE_W-1:0] irdata_q;
    logic [LINE_W-1:0] drdata_q;
    logic              l2_read_q;
    logic              l2_write_q;
    logic              iresp_q;
    logic              dresp_q;

    logic w_dreq;
    logic w_any;
    logic w_dgrant;
    logic w_dwrite;

    assign w_dreq   = dcache_read | dcache_write;
    assign w_any    = w_dreq | icache_read;
    assign w_dgrant = w_dreq & ((starve_q < c_STARVE_MAX) | ~icache_read);
    // A simultaneous read and write from the dcache is serviced as the write.
    assign w_dwrite = w_dgrant & dcache_write;

    always_comb begin
        starve_d = 4'd0;
        if (w_dgrant && icache_read) begin
            starve_d = (starve_q == c_STARVE_SAT) ? c_STARVE_SAT : starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            owner_dc_q <= 1'b0;
            starve_q   <= 4'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            irdata_q   <= '0;
            drdata_q   <= '0;
            l2_read_q  <= 1'b0;
            l2_write_q <= 1'b0;
            iresp_q    <= 1'b0;
            dresp_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    iresp_q <= 1'b0;
                    dresp_q <= 1'b0;
                    if (w_any) begin
                        owner_dc_q <= w_dgrant;
                        addr_q     <= w_dgrant ? dcache_address : icache_address;
                        if (w_dwrite) begin
                            wdata_q <= dcache_wdata;
                        end
                        l2_write_q <= w_dwrite;
                        l2_read_q  <= ~w_dwrite;
                        starve_q   <= starve_d;
                        state_q    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (l2_resp) begin
                        if (!l2_write_q) begin
                            if (owner_dc_q) begin
                                drdata_q <= l2cache_rdata;
                            end else begin
                                irdata_q <= l2cache_rdata;
                            end
                        end
                        l2_read_q  <= 1'b0;
                        l2_write_q <= 1'b0;
                        iresp_q    <= ~owner_dc_q;
                        dresp_q    <= owner_dc_q;
                        state_q    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    iresp_q <= 1'b0;
                    dresp_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign icache_rdata    = irdata_q;
    assign icache_resp     = iresp_q;
    assign dcache_rdata    = drdata_q;
    assign dcache_resp     = dresp_q;
    assign l2cache_address = addr_q;
    assign l2cache_wdata   = wdata_q;
    assign l2_read         = l2_read_q;
    assign l2_write        = l2_write_q;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_igrant_q;
    logic [31:0] perf_dgrant_q;
    logic [31:0] perf_wait_q;
    logic        w_grant;
    logic        w_wait;

    assign w_grant = (state_q == ST_IDLE) & w_any;
    assign w_wait  = (state_q != ST_IDLE) & w_any;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_igrant_q <= 32'd0;
            perf_dgrant_q <= 32'd0;
            perf_wait_q   <= 32'd0;
        end else begin
            if (w_grant && !w_dgrant && perf_igrant_q != 32'hFFFF_FFFF) begin
                perf_igrant_q <= perf_igrant_q + 32'd1;
            end
            if (w_grant && w_dgrant && perf_dgrant_q != 32'hFFFF_FFFF) begin
                perf_dgrant_q <= perf_dgrant_q + 32'd1;
            end
            if (w_wait && perf_wait_q != 32'hFFFF_FFFF) begin
                perf_wait_q <= perf_wait_q + 32'd1;
            end
        end
    end

    assign perf_igrant = perf_igrant_q;
    assign perf_dgrant = perf_dgrant_q;
    assign perf_wait   = perf_wait_q;
`else
    assign perf_igrant = 32'd0;
    assign perf_dgrant = 32'd0;
    assign perf_wait   = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_l2_request_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_l2_request_scheduler
// Description : Scoreboard bench for l2_request_scheduler with autonomous
//               requester and L2 models.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_l2_request_scheduler;

    localparam int K_RD = 0;
    localparam int K_WR = 1;
    localparam int K_IR = 2;
    localparam int K_DR = 3;

    typedef struct {
        int           kind;
        logic [15:0]  addr;
        logic [127:0] data;
        time          t;
    } ev_t;

    typedef struct {
        logic         rd;
        logic         wr;
        logic [15:0]  addr;
        logic [127:0] wdata;
    } dop_t;

    logic         clk            = 1'b0;
    logic         rst_n          = 1'b0;
    logic         icache_read    = 1'b0;
    logic [15:0]  icache_address = 16'h0;
    logic         dcache_read    = 1'b0;
    logic         dcache_write   = 1'b0;
    logic [15:0]  dcache_address = 16'h0;
    logic [127:0] dcache_wdata   = '0;
    logic [127:0] l2cache_rdata  = '0;
    logic         l2_resp        = 1'b0;
    logic [127:0] icache_rdata;
    logic         icache_resp;
    logic [127:0] dcache_rdata;
    logic         dcache_resp;
    logic [15:0]  l2cache_address;
    logic [127:0] l2cache_wdata;
    logic         l2_read;
    logic         l2_write;
    logic [31:0]  perf_igrant;
    logic [31:0]  perf_dgrant;
    logic [31:0]  perf_wait;

    ev_t          exp_q[$];
    ev_t          obs_q[$];
    logic [15:0]  iq[$];
    dop_t         dq[$];
    int           vecs = 0;
    int           errs = 0;
    int           viol = 0;
    int           l2_delay = 2;
    int           wcnt = 0;
    logic         prev_cmd = 1'b0;
    logic [15:0]  prev_addr = 16'h0;
    time          i_raise_t = 0;
    logic [127:0] exp_drd = '0;
    int           exp_ig = 0;
    int           exp_dg = 0;

    l2_request_scheduler #(
        .ADDR_W    (16),
        .LINE_W    (128),
        .STARVE_MAX(4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .icache_read    (icache_read),
        .icache_address (icache_address),
        .icache_rdata   (icache_rdata),
        .icache_resp    (icache_resp),
        .dcache_read    (dcache_read),
        .dcache_write   (dcache_write),
        .dcache_address (dcache_address),
        .dcache_wdata   (dcache_wdata),
        .dcache_rdata   (dcache_rdata),
        .dcache_resp    (dcache_resp),
        .l2cache_address(l2cache_address),
        .l2cache_wdata  (l2cache_wdata),
        .l2_read        (l2_read),
        .l2_write       (l2_write),
        .l2cache_rdata  (l2cache_rdata),
        .l2_resp        (l2_resp),
        .perf_igrant    (perf_igrant),
        .perf_dgrant    (perf_dgrant),
        .perf_wait      (perf_wait)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] line_of(input logic [15:0] a);
        return {a, ~a, a ^ 16'h1234, 16'hC0DE, a, ~a, 16'h5A5A, a + 16'd7};
    endfunction

    function automatic void push_ev(input int kind, input logic [15:0] addr, input logic [127:0] data);
        ev_t e;
        e.kind = kind;
        e.addr = addr;
        e.data = data;
        e.t    = 0;
        exp_q.push_back(e);
    endfunction

    function automatic void exp_rd_i(input logic [15:0] addr);
        push_ev(K_RD, addr, '0);
        push_ev(K_IR, 16'h0, line_of(addr));
        exp_ig++;
    endfunction

    function automatic void exp_rd_d(input logic [15:0] addr);
        push_ev(K_RD, addr, '0);
        push_ev(K_DR, 16'h0, line_of(addr));
        exp_drd = line_of(addr);
        exp_dg++;
    endfunction

    function automatic void exp_wr_d(input logic [15:0] addr, input logic [127:0] w);
        push_ev(K_WR, addr, w);
        push_ev(K_DR, 16'h0, exp_drd);
        exp_dg++;
    endfunction

    function automatic void dreq(input logic rd, input logic wr, input logic [15:0] addr, input logic [127:0] w);
        dop_t d;
        d.rd = rd;
        d.wr = wr;
        d.addr = addr;
        d.wdata = w;
        dq.push_back(d);
    endfunction

    // Requesters hold until their resp and re-request at once from their queue.
    always @(negedge clk) begin
        dop_t d;
        if (icache_resp) icache_read = 1'b0;
        if (!icache_read && iq.size() > 0) begin
            icache_address = iq.pop_front();
            icache_read    = 1'b1;
            i_raise_t      = $time;
        end
        if (dcache_resp) begin
            dcache_read  = 1'b0;
            dcache_write = 1'b0;
        end
        if (!dcache_read && !dcache_write && dq.size() > 0) begin
            d = dq.pop_front();
            dcache_read    = d.rd;
            dcache_write   = d.wr;
            dcache_address = d.addr;
            dcache_wdata   = d.wdata;
        end
    end

    // L2 answers l2_delay cycles after first seeing a command.
    always @(negedge clk) begin
        if (l2_resp) begin
            l2_resp = 1'b0;
            wcnt    = 0;
        end else if (l2_read || l2_write) begin
            if (wcnt == l2_delay) begin
                l2_resp       = 1'b1;
                l2cache_rdata = line_of(l2cache_address);
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
    end

    always @(negedge clk) begin
        ev_t e;
        e.t = $time;
        if ((l2_read || l2_write) && !prev_cmd) begin
            e.kind = l2_write ? K_WR : K_RD;
            e.addr = l2cache_address;
            e.data = l2_write ? l2cache_wdata : '0;
            obs_q.push_back(e);
        end
        if ((l2_read || l2_write) && prev_cmd && l2cache_address !== prev_addr) viol++;
        if (l2_read && l2_write) viol++;
        if (icache_resp && dcache_resp) viol++;
        if (icache_resp) begin
            e.kind = K_IR;
            e.addr = 16'h0;
            e.data = icache_rdata;
            obs_q.push_back(e);
        end
        if (dcache_resp) begin
            e.kind = K_DR;
            e.addr = 16'h0;
            e.data = dcache_rdata;
            obs_q.push_back(e);
        end
        prev_cmd  = l2_read | l2_write;
        prev_addr = l2cache_address;
    end

    task automatic wait_drain(input int budget, output bit ok);
        for (int i = 0; i < budget && obs_q.size() < exp_q.size(); i++) @(negedge clk);
        repeat (3) @(negedge clk);
        ok = (obs_q.size() >= exp_q.size());
    endtask

    task automatic test_reset;
        @(negedge clk);
        vecs++;
        if ({l2_read, l2_write, icache_resp, dcache_resp} !== 4'b0) begin
            $display("FAIL reset_ctrl: got %b want 0000", {l2_read, l2_write, icache_resp, dcache_resp});
            errs++;
        end
        vecs++;
        if (l2cache_address !== 16'h0 || l2cache_wdata !== 128'h0) begin
            $display("FAIL reset_l2bus: got addr=%h wdata=%h want 0/0", l2cache_address, l2cache_wdata);
            errs++;
        end
        vecs++;
        if (icache_rdata !== 128'h0 || dcache_rdata !== 128'h0) begin
            $display("FAIL reset_rdata: got i=%h d=%h want 0/0", icache_rdata, dcache_rdata);
            errs++;
        end
        vecs++;
        if ({perf_igrant, perf_dgrant, perf_wait} !== 96'h0) begin
            $display("FAIL reset_perf: got %0d/%0d/%0d want 0/0/0", perf_igrant, perf_dgrant, perf_wait);
            errs++;
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        vecs++;
        if (l2_read !== 1'b0 || obs_q.size() != 0) begin
            $display("FAIL idle_no_req: got l2_read=%b events=%0d want 0/0", l2_read, obs_q.size());
            errs++;
        end
    endtask

    task automatic test_single;
        bit  ok;
        ev_t c;
        ev_t r;
        l2_delay = 2;
        exp_rd_i(16'h1000);
        iq.push_back(16'h1000);
        wait_drain(100, ok);
        vecs++;
        if (!ok || obs_q.size() != 2) begin
            $display("FAIL single_events: got %0d events want 2", obs_q.size());
            errs++;
            obs_q.delete();
            exp_q.delete();
        end else begin
            c = obs_q.pop_front();
            r = obs_q.pop_front();
            void'(exp_q.pop_front());
            void'(exp_q.pop_front());
            vecs++;
            if (c.kind !== K_RD || c.addr !== 16'h1000) begin
                $display("FAIL single_cmd: got kind=%0d addr=%h want %0d/1000", c.kind, c.addr, K_RD);
                errs++;
            end
            vecs++;
            if (c.t - i_raise_t !== 10) begin
                $display("FAIL single_cmd_lat: got %0t want 10", c.t - i_raise_t);
                errs++;
            end
            vecs++;
            if (r.kind !== K_IR || r.data !== line_of(16'h1000)) begin
                $display("FAIL single_resp: got kind=%0d data=%h want %0d/%h", r.kind, r.data, K_IR, line_of(16'h1000));
                errs++;
            end
            vecs++;
            if (r.t - c.t !== 30) begin
                $display("FAIL single_resp_lat: got %0t want 30", r.t - c.t);
                errs++;
            end
        end
    endtask

    task automatic test_dcache_priority;
        bit  ok;
        ev_t e;
        ev_t o;
        exp_wr_d(16'h2000, {4{32'hDEAD_BEEF}});
        exp_rd_i(16'h3000);
        dreq(1'b0, 1'b1, 16'h2000, {4{32'hDEAD_BEEF}});
        iq.push_back(16'h3000);
        wait_drain(200, ok);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vecs++;
            if (obs_q.size() == 0) begin
                $display("FAIL prio: missing event kind=%0d", e.kind);
                errs++;
            end else begin
                o = obs_q.pop_front();
                if (o.kind !== e.kind || o.addr !== e.addr || o.data !== e.data) begin
                    $display("FAIL prio: got %0d/%h/%h want %0d/%h/%h", o.kind, o.addr, o.data, e.kind, e.addr, e.data);
                    errs++;
                end
            end
        end
        vecs++;
        if (obs_q.size() != 0) begin
            $display("FAIL prio_extra: got %0d extra events want 0", obs_q.size());
            errs++;
            obs_q.delete();
        end
    endtask

    task automatic test_starvation;
        bit  ok;
        ev_t e;
        ev_t o;
        for (int k = 0; k < 4; k++) exp_rd_d(16'h7000 + 16'(k));
        exp_rd_i(16'h6000);
        for (int k = 4; k < 8; k++) exp_rd_d(16'h7000 + 16'(k));
        exp_rd_i(16'h6001);
        for (int k = 0; k < 8; k++) dreq(1'b1, 1'b0, 16'h7000 + 16'(k), '0);
        iq.push_back(16'h6000);
        iq.push_back(16'h6001);
        wait_drain(400, ok);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vecs++;
            if (obs_q.size() == 0) begin
                $display("FAIL starve: missing event kind=%0d addr=%h", e.kind, e.addr);
                errs++;
            end else begin
                o = obs_q.pop_front();
                if (o.kind !== e.kind || o.addr !== e.addr || o.data !== e.data) begin
                    $display("FAIL starve: got %0d/%h/%h want %0d/%h/%h", o.kind, o.addr, o.data, e.kind, e.addr, e.data);
                    errs++;
                end
            end
        end
        vecs++;
        if (obs_q.size() != 0) begin
            $display("FAIL starve_extra: got %0d extra events want 0", obs_q.size());
            errs++;
            obs_q.delete();
        end
    endtask

    task automatic test_read_write_collision;
        bit  ok;
        ev_t e;
        ev_t o;
        exp_wr_d(16'h4000, {8{16'h0F0F}});
        dreq(1'b1, 1'b1, 16'h4000, {8{16'h0F0F}});
        wait_drain(100, ok);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vecs++;
            if (obs_q.size() == 0) begin
                $display("FAIL rw_collide: missing event kind=%0d", e.kind);
                errs++;
            end else begin
                o = obs_q.pop_front();
                if (o.kind !== e.kind || o.addr !== e.addr || o.data !== e.data) begin
                    $display("FAIL rw_collide: got %0d/%h/%h want %0d/%h/%h", o.kind, o.addr, o.data, e.kind, e.addr, e.data);
                    errs++;
                end
            end
        end
        vecs++;
        if (obs_q.size() != 0) begin
            $display("FAIL rw_collide_extra: got %0d extra events want 0", obs_q.size());
            errs++;
            obs_q.delete();
        end
    endtask

    task automatic test_reset_mid_busy;
        bit  ok;
        ev_t e;
        ev_t o;
        int  n;
        l2_delay = 6;
        push_ev(K_RD, 16'h5000, '0);
        iq.push_back(16'h5000);
        n = 0;
        while (l2_read !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        vecs++;
        if (l2_read !== 1'b1) begin
            $display("FAIL rst_busy_start: got l2_read=%b want 1", l2_read);
            errs++;
        end
        rst_n = 1'b0;
        @(negedge clk);
        vecs++;
        if (l2_read !== 1'b0 || icache_resp !== 1'b0) begin
            $display("FAIL rst_busy_drop: got l2_read=%b resp=%b want 0/0", l2_read, icache_resp);
            errs++;
        end
        rst_n    = 1'b1;
        l2_delay = 2;
        exp_drd  = '0;
        exp_ig   = 0;
        exp_dg   = 0;
        exp_rd_i(16'h5000);
        wait_drain(100, ok);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vecs++;
            if (obs_q.size() == 0) begin
                $display("FAIL rst_busy: missing event kind=%0d", e.kind);
                errs++;
            end else begin
                o = obs_q.pop_front();
                if (o.kind !== e.kind || o.addr !== e.addr || o.data !== e.data) begin
                    $display("FAIL rst_busy: got %0d/%h/%h want %0d/%h/%h", o.kind, o.addr, o.data, e.kind, e.addr, e.data);
                    errs++;
                end
            end
        end
        vecs++;
        if (obs_q.size() != 0) begin
            $display("FAIL rst_busy_extra: got %0d extra events want 0", obs_q.size());
            errs++;
            obs_q.delete();
        end
    endtask

    task automatic test_perf;
        bit  ok;
        ev_t e;
        ev_t o;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
        exp_ig  = 0;
        exp_dg  = 0;
        exp_drd = '0;
        exp_rd_d(16'h8000);
        exp_rd_d(16'h8001);
        exp_rd_i(16'h9000);
        exp_rd_i(16'h9001);
        exp_rd_i(16'h9002);
        dreq(1'b1, 1'b0, 16'h8000, '0);
        dreq(1'b1, 1'b0, 16'h8001, '0);
        iq.push_back(16'h9000);
        iq.push_back(16'h9001);
        iq.push_back(16'h9002);
        wait_drain(300, ok);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vecs++;
            if (obs_q.size() == 0) begin
                $display("FAIL perf_seq: missing event kind=%0d", e.kind);
                errs++;
            end else begin
                o = obs_q.pop_front();
                if (o.kind !== e.kind || o.addr !== e.addr || o.data !== e.data) begin
                    $display("FAIL perf_seq: got %0d/%h/%h want %0d/%h/%h", o.kind, o.addr, o.data, e.kind, e.addr, e.data);
                    errs++;
                end
            end
        end
        obs_q.delete();
`ifdef ARB_PERF_CNT_EN
        vecs++;
        if (perf_igrant !== 32'(exp_ig) || perf_dgrant !== 32'(exp_dg)) begin
            $display("FAIL perf_grants: got %0d/%0d want %0d/%0d", perf_igrant, perf_dgrant, exp_ig, exp_dg);
            errs++;
        end
        vecs++;
        if (perf_wait === 32'd0) begin
            $display("FAIL perf_wait: got 0 want nonzero");
            errs++;
        end
`else
        vecs++;
        if ({perf_igrant, perf_dgrant, perf_wait} !== 96'h0) begin
            $display("FAIL perf_off: got %0d/%0d/%0d want 0/0/0", perf_igrant, perf_dgrant, perf_wait);
            errs++;
        end
`endif
    endtask

    task automatic test_invariants;
        vecs++;
        if (viol !== 0) begin
            $display("FAIL invariants: got %0d violations want 0", viol);
            errs++;
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_dcache_priority;
        test_starvation;
        test_read_write_collision;
        test_reset_mid_busy;
        test_perf;
        test_invariants;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
`default_nettype wire
